// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The master side is the controller: it consumes decode fields and drives every select/enable.
interface mips_multicycle_control_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;

    logic               pc_en;
    logic               i_or_d;
    logic               mem_write;
    logic               ir_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic               imm_zero_ext;
    logic [1:0]         pc_src;
    logic [3:0]         alu_control;
    logic               illegal_op;
    logic [STATE_W-1:0] state;

    modport master (
        input  op, funct, zero,
        output pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, imm_zero_ext, pc_src, alu_control, illegal_op, state
    );

    modport slave (
        output op, funct, zero,
        input  pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, imm_zero_ext, pc_src, alu_control, illegal_op, state
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives all mux selects and enables.
module mips_multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    mips_multicycle_control_if.master ctl
);

    typedef enum logic [STATE_W-1:0] {
        FETCH   = STATE_W'(0),
        DECODE  = STATE_W'(1),
        MEMADR  = STATE_W'(2),
        MEMRD   = STATE_W'(3),
        MEMWB   = STATE_W'(4),
        MEMWR   = STATE_W'(5),
        RTYPEEX = STATE_W'(6),
        RTYPEWB = STATE_W'(7),
        BEQEX   = STATE_W'(8),
        BNEEX   = STATE_W'(9),
        IMMEX   = STATE_W'(10),
        IMMWB   = STATE_W'(11),
        JEX     = STATE_W'(12)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] funct_q;

    logic       pc_en_c;
    logic       ir_write_c;
    logic       mem_write_c;
    logic       reg_write_c;
    logic       i_or_d_c;
    logic       reg_dst_c;
    logic       mem_to_reg_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic       imm_zero_ext_c;
    logic [1:0] pc_src_c;
    logic [3:0] alu_control_c;
    logic       illegal_op_c;

    function automatic logic rtype_legal(input logic [5:0] f);
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLL, FN_SRL: return 1'b1;
            default:                                                       return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] rtype_alu(input logic [5:0] f);
        case (f)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_NOR:  return ALU_NOR;
            FN_SLT:  return ALU_SLT;
            FN_SLL:  return ALU_SLL;
            FN_SRL:  return ALU_SRL;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [3:0] imm_alu(input logic [5:0] o);
        case (o)
            OP_SLTI: return ALU_SLT;
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

    // Shifts take their A operand from the shamt field rather than register A.
    function automatic logic is_shift(input logic [5:0] f);
        return (f == FN_SLL) || (f == FN_SRL);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // funct is only guaranteed valid in DECODE, so R-type execute/writeback use this copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct_q <= 6'b000000;
        end else if (state_q == DECODE) begin
            funct_q <= ctl.funct;
        end
    end

    always_comb begin
        state_d        = FETCH;
        pc_en_c        = 1'b0;
        ir_write_c     = 1'b0;
        mem_write_c    = 1'b0;
        reg_write_c    = 1'b0;
        i_or_d_c       = 1'b0;
        reg_dst_c      = 1'b0;
        mem_to_reg_c   = 1'b0;
        alu_src_a_c    = 2'b00;
        alu_src_b_c    = 2'b00;
        imm_zero_ext_c = 1'b0;
        pc_src_c       = 2'b00;
        alu_control_c  = ALU_ADD;
        illegal_op_c   = 1'b0;

        case (state_q)
            FETCH: begin
                ir_write_c  = 1'b1;
                alu_src_b_c = 2'b01;
                pc_en_c     = 1'b1;
                state_d     = DECODE;
            end
            DECODE: begin
                alu_src_b_c = 2'b11;
                case (ctl.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE: begin
                        if (rtype_legal(ctl.funct)) begin
                            state_d = RTYPEEX;
                        end else begin
                            illegal_op_c = 1'b1;
                        end
                    end
                    OP_BEQ:                            state_d = BEQEX;
                    OP_BNE:                            state_d = BNEEX;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = IMMEX;
                    OP_J:                              state_d = JEX;
                    default:                           illegal_op_c = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                state_d     = (ctl.op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                i_or_d_c = 1'b1;
                state_d  = MEMWB;
            end
            MEMWB: begin
                mem_to_reg_c = 1'b1;
                reg_write_c  = 1'b1;
            end
            MEMWR: begin
                i_or_d_c    = 1'b1;
                mem_write_c = 1'b1;
            end
            RTYPEEX: begin
                alu_src_a_c   = is_shift(funct_q) ? 2'b10 : 2'b01;
                alu_control_c = rtype_alu(funct_q);
                state_d       = RTYPEWB;
            end
            RTYPEWB: begin
                reg_dst_c     = 1'b1;
                reg_write_c   = 1'b1;
                alu_control_c = rtype_alu(funct_q);
            end
            BEQEX: begin
                alu_src_a_c   = 2'b01;
                alu_control_c = ALU_SUB;
                pc_src_c      = 2'b01;
                pc_en_c       = ctl.zero;
            end
            BNEEX: begin
                alu_src_a_c   = 2'b01;
                alu_control_c = ALU_SUB;
                pc_src_c      = 2'b01;
                pc_en_c       = ~ctl.zero;
            end
            IMMEX, IMMWB: begin
                alu_src_a_c    = 2'b01;
                alu_src_b_c    = 2'b10;
                alu_control_c  = imm_alu(ctl.op);
                imm_zero_ext_c = (ctl.op == OP_ANDI) || (ctl.op == OP_ORI);
                reg_write_c    = (state_q == IMMWB);
                state_d        = (state_q == IMMEX) ? IMMWB : FETCH;
            end
            JEX: begin
                pc_src_c = 2'b10;
                pc_en_c  = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Reset is asynchronous, so enables are gated directly by rst to stay quiet in the assertion cycle.
    assign ctl.pc_en        = pc_en_c & ~rst;
    assign ctl.ir_write     = ir_write_c & ~rst;
    assign ctl.mem_write    = mem_write_c & ~rst;
    assign ctl.reg_write    = reg_write_c & ~rst;
    assign ctl.i_or_d       = i_or_d_c;
    assign ctl.reg_dst      = reg_dst_c;
    assign ctl.mem_to_reg   = mem_to_reg_c;
    assign ctl.alu_src_a    = alu_src_a_c;
    assign ctl.alu_src_b    = alu_src_b_c;
    assign ctl.imm_zero_ext = imm_zero_ext_c;
    assign ctl.pc_src       = pc_src_c;
    assign ctl.alu_control  = alu_control_c;
    assign ctl.illegal_op   = illegal_op_c;
    assign ctl.state        = state_q;

endmodule
